// File: rtl/uxa_ps2_fifo_ctl.sv
// uxa_ps2_fifo_ctl: write sequencer and read-only bus front-end for a 16-entry PS/2 byte FIFO.
//
// Received bytes are written into the external FIFO with a two-cycle sequence:
// a write strobe, then a write-pointer bump. One byte that arrives while a
// sequence is running is held in a pending register. The bus port exposes two
// read-only registers:
//   - adr 0, DATA: pops the FIFO head.
//   - adr 1, STATUS: {level[3:0], 0, overflow, full, avail}.
// Reading STATUS clears the sticky overflow flag.
//
// Ports:
//   sys_clk_i, sys_reset_n_i : clock and async active-low reset (shared with the FIFO)
//   rx_data_i, rx_stb_i      : byte and one-cycle strobe from the PS/2 deserializer
//   fifo_d_o, fifo_we_o      : FIFO write data / write enable
//   fifo_wp_inc_o            : FIFO write-pointer increment
//   fifo_rp_inc_o            : FIFO read-pointer increment (pop)
//   fifo_q_i                 : FIFO head byte
//   bus_rd_i, bus_adr_i      : read request and register select
//   bus_dat_o, bus_ack_o     : read data and one-cycle acknowledge
//   irq_o                    : (UXA_PS2_FIFO_IRQ_EN only) level!=0 | overflow, registered
//
// Optional feature macro: UXA_PS2_FIFO_IRQ_EN adds the irq_o output.

module uxa_ps2_fifo_ctl #(
  parameter int unsigned LEVEL_MAX = 15,
  parameter int unsigned LEVEL_W   = 4
) (
  input  logic       sys_clk_i,
  input  logic       sys_reset_n_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_stb_i,
  output logic [7:0] fifo_d_o,
  output logic       fifo_we_o,
  output logic       fifo_wp_inc_o,
  output logic       fifo_rp_inc_o,
  input  logic [7:0] fifo_q_i,
  input  logic       bus_rd_i,
  input  logic       bus_adr_i,
  output logic [7:0] bus_dat_o,
  output logic       bus_ack_o
`ifdef UXA_PS2_FIFO_IRQ_EN
  ,
  output logic       irq_o
`endif
);

  typedef enum logic [1:0] {StIdle, StWrite, StBump} state_e;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               pend_v_q, pend_v_d;
  logic [7:0]         pend_q, pend_d;
  logic [7:0]         hold_q, hold_d;
  logic               ack_q, ack_d;
  logic [7:0]         dat_q, dat_d;
  logic               pop_q, pop_d;

  logic               ovf_set;
  logic               bump;
  logic               level_full;
  logic               level_nz;
  logic               rd_acc;
  logic [7:0]         src;
  logic [3:0]         level4;
  logic [7:0]         status;

  assign bump       = (state_q == StBump);
  assign level_full = (level_q == LEVEL_W'(LEVEL_MAX));
  assign level_nz   = (level_q != '0);
  assign level4     = 4'(level_q);
  assign status     = {level4, 1'b0, ovf_q, level_full, level_nz};
  // A read is ignored while its predecessor is still being acknowledged.
  assign rd_acc     = bus_rd_i & ~ack_q;

  // Level counter: the pop is the registered rp_inc, so a bump and a pop in
  // the same cycle cancel out.
  always_comb begin
    level_d = level_q;
    unique case ({bump, pop_q})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Write sequencer and pending-byte handling.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    ovf_set  = 1'b0;
    src      = pend_v_q ? pend_q : rx_data_i;

    unique case (state_q)
      StIdle: begin
        if (pend_v_q || rx_stb_i) begin
          if (pend_v_q) begin
            // Pending byte is consumed here; a simultaneous strobe refills it.
            pend_v_d = rx_stb_i;
            if (rx_stb_i) pend_d = rx_data_i;
          end
          if (level_full) begin
            ovf_set = 1'b1;
          end else begin
            hold_d  = src;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        state_d = StBump;
        if (rx_stb_i) begin
          if (pend_v_q) begin
            ovf_set = 1'b1;
          end else begin
            pend_v_d = 1'b1;
            pend_d   = rx_data_i;
          end
        end
      end
      StBump: begin
        state_d = StIdle;
        if (pend_v_q) begin
          // Level test uses the post-update level, including a concurrent pop.
          if (level_d < LEVEL_W'(LEVEL_MAX)) begin
            hold_d  = pend_q;
            state_d = StWrite;
          end else begin
            ovf_set = 1'b1;
          end
        end
        // Pending is always emptied here, so a strobe can always land in it.
        pend_v_d = rx_stb_i;
        if (rx_stb_i) pend_d = rx_data_i;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus read path.
  always_comb begin
    ack_d = rd_acc;
    dat_d = 8'h00;
    pop_d = 1'b0;
    if (rd_acc) begin
      if (bus_adr_i) begin
        dat_d = status;
      end else if (level_nz) begin
        dat_d = fifo_q_i;
        pop_d = 1'b1;
      end
    end
    // A new overflow event beats the read-to-clear.
    ovf_d = ovf_set | (ovf_q & ~(rd_acc & bus_adr_i));
  end

  always_ff @(posedge sys_clk_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      state_q  <= StIdle;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      pend_v_q <= 1'b0;
      pend_q   <= 8'h00;
      hold_q   <= 8'h00;
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      pop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      pop_q    <= pop_d;
    end
  end

  assign fifo_d_o      = hold_q;
  assign fifo_we_o     = (state_q == StWrite);
  assign fifo_wp_inc_o = (state_q == StBump);
  assign fifo_rp_inc_o = pop_q;
  assign bus_dat_o     = dat_q;
  assign bus_ack_o     = ack_q;

`ifdef UXA_PS2_FIFO_IRQ_EN
  logic irq_q;

  always_ff @(posedge sys_clk_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= level_nz | ovf_q;
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_uxa_ps2_fifo_ctl.sv
// Testbench for uxa_ps2_fifo_ctl: a behavioural FIFO memory plus a cycle-level
// reference model. Expected writes and read responses are queued by the model
// and popped by an independent monitor when the DUT presents them.

module tb_uxa_ps2_fifo_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_stb = 1'b0;
  logic [7:0] fifo_d;
  logic       fifo_we, fifo_wpi, fifo_rpi;
  logic [7:0] fifo_q;
  logic       bus_rd = 1'b0;
  logic       bus_adr = 1'b0;
  logic [7:0] bus_dat;
  logic       bus_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uxa_ps2_fifo_ctl dut (
    .sys_clk_i    (clk),
    .sys_reset_n_i(rst_n),
    .rx_data_i    (rx_data),
    .rx_stb_i     (rx_stb),
    .fifo_d_o     (fifo_d),
    .fifo_we_o    (fifo_we),
    .fifo_wp_inc_o(fifo_wpi),
    .fifo_rp_inc_o(fifo_rpi),
    .fifo_q_i     (fifo_q),
    .bus_rd_i     (bus_rd),
    .bus_adr_i    (bus_adr),
    .bus_dat_o    (bus_dat),
    .bus_ack_o    (bus_ack)
  );

  // Behavioural 16-entry FIFO, reset together with the DUT.
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 4'd0;
      rp <= 4'd0;
    end else begin
      if (fifo_we)  mem[wp] <= fifo_d;
      if (fifo_wpi) wp <= wp + 4'd1;
      if (fifo_rpi) rp <= rp + 4'd1;
    end
  end
  assign fifo_q = mem[rp];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] dat;
    bit         pop;
  } rd_t;

  rd_t        rd_exp[$];
  logic [7:0] wr_exp[$];
  logic [7:0] m_pend[$];   // at most one byte waiting behind the active write
  logic [7:0] m_fifo[$];   // bytes committed to the FIFO, oldest first
  int         m_lvl = 0;
  bit         m_ovf = 0;
  int         m_ph  = 0;   // 0 idle, 1 write-strobe cycle, 2 bump cycle
  logic [7:0] m_cur = 8'h00;
  bit         m_ack = 0;
  bit         m_pop = 0;

  always @(posedge clk or negedge rst_n) begin
    int         new_lvl;
    bit         set_ovf;
    bit         acc;
    logic [7:0] b;
    rd_t        r;
    if (!rst_n) begin
      rd_exp.delete();
      wr_exp.delete();
      m_pend.delete();
      m_fifo.delete();
      m_lvl = 0;
      m_ovf = 0;
      m_ph  = 0;
      m_ack = 0;
      m_pop = 0;
    end else begin
      new_lvl = m_lvl + int'(m_ph == 2) - int'(m_pop);
      set_ovf = 0;
      acc     = bus_rd && !m_ack;
      r.dat   = 8'h00;
      r.pop   = 0;
      if (acc) begin
        if (bus_adr) begin
          r.dat = {4'(m_lvl), 1'b0, m_ovf, (m_lvl == 15), (m_lvl != 0)};
        end else if (m_lvl != 0) begin
          r.dat = m_fifo[0];
          r.pop = 1;
        end
        rd_exp.push_back(r);
      end
      if (m_pop) void'(m_fifo.pop_front());
      if (m_ph == 2) m_fifo.push_back(m_cur);

      if (m_ph == 0) begin
        if (m_pend.size() > 0 || rx_stb) begin
          if (m_pend.size() > 0) begin
            b = m_pend.pop_front();
            if (rx_stb) m_pend.push_back(rx_data);
          end else begin
            b = rx_data;
          end
          if (m_lvl == 15) begin
            set_ovf = 1;
          end else begin
            m_cur = b;
            m_ph  = 1;
            wr_exp.push_back(b);
          end
        end
      end else if (m_ph == 1) begin
        m_ph = 2;
        if (rx_stb) begin
          if (m_pend.size() > 0) set_ovf = 1;
          else m_pend.push_back(rx_data);
        end
      end else begin
        m_ph = 0;
        if (m_pend.size() > 0) begin
          b = m_pend.pop_front();
          if (new_lvl < 15) begin
            m_cur = b;
            m_ph  = 1;
            wr_exp.push_back(b);
          end else begin
            set_ovf = 1;
          end
        end
        if (rx_stb) m_pend.push_back(rx_data);
      end

      m_ovf = set_ovf | (m_ovf & !(acc && bus_adr));
      m_lvl = new_lvl;
      m_ack = acc;
      m_pop = acc && r.pop;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    rd_t        e;
    logic [7:0] w;
    chk("we_timing", int'(fifo_we), int'(m_ph == 1));
    chk("wp_inc_timing", int'(fifo_wpi), int'(m_ph == 2));
    if (fifo_we) begin
      if (wr_exp.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        w = wr_exp.pop_front();
        chk("fifo_d", int'(fifo_d), int'(w));
      end
    end
    if (bus_ack) begin
      if (rd_exp.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e = rd_exp.pop_front();
        chk("bus_dat", int'(bus_dat), int'(e.dat));
        chk("rp_inc", int'(fifo_rpi), int'(e.pop));
      end
    end else begin
      chk("idle_dat", int'(bus_dat), 0);
      chk("idle_rp_inc", int'(fifo_rpi), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
  endtask

  task automatic bus_read(input logic adr, output logic [7:0] d);
    bus_rd  = 1'b1;
    bus_adr = adr;
    @(negedge clk);
    bus_rd  = 1'b0;
    chk("ack_latency", int'(bus_ack), 1);
    d = bus_dat;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_we", int'(fifo_we), 0);
    chk("rst_wpi", int'(fifo_wpi), 0);
    chk("rst_rpi", int'(fifo_rpi), 0);
    chk("rst_d", int'(fifo_d), 0);
    chk("rst_ack", int'(bus_ack), 0);
    bus_read(1'b1, d);
    chk("rst_status", int'(d), 8'h00);

    // Single byte.
    send(8'hB7);
    cyc(4);
    bus_read(1'b1, d);
    chk("single_status", int'(d), 8'h11);
    bus_read(1'b0, d);
    chk("single_data", int'(d), 8'hB7);
    bus_read(1'b1, d);
    chk("single_status_after", int'(d), 8'h00);

    // Back-to-back strobes.
    send(8'h01);
    send(8'h02);
    cyc(6);
    bus_read(1'b1, d);
    chk("b2b_status", int'(d), 8'h21);
    bus_read(1'b0, d);
    chk("b2b_data0", int'(d), 8'h01);
    bus_read(1'b0, d);
    chk("b2b_data1", int'(d), 8'h02);

    // Overfill: 20 bytes, 15 fit.
    for (int i = 1; i <= 20; i++) begin
      send(8'(i));
      cyc(3);
    end
    bus_read(1'b1, d);
    chk("full_status", int'(d), 8'hF7);
    bus_read(1'b1, d);
    chk("full_status2", int'(d), 8'hF3);
    for (int i = 1; i <= 15; i++) begin
      bus_read(1'b0, d);
      chk("full_drain", int'(d), i);
    end
    bus_read(1'b1, d);
    chk("full_status_end", int'(d), 8'h00);

    // Empty DATA read.
    bus_read(1'b0, d);
    chk("empty_data", int'(d), 8'h00);

    // Pop concurrent with bump at level 3.
    send(8'h31);
    send(8'h32);
    send(8'h33);
    cyc(8);
    rx_data = 8'h34;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
    bus_read(1'b0, d);
    chk("concurrent_data", int'(d), 8'h31);
    cyc(3);
    bus_read(1'b1, d);
    chk("concurrent_status", int'(d), 8'h31);
    for (int i = 2; i <= 4; i++) begin
      bus_read(1'b0, d);
      chk("concurrent_drain", int'(d), 8'h30 + i);
    end

    // Reset in the middle of a write sequence.
    send(8'hAA);
    chk("pre_rst_we", int'(fifo_we), 1);
    chk("pre_rst_d", int'(fifo_d), 8'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", int'(fifo_we), 0);
    chk("async_rst_wpi", int'(fifo_wpi), 0);
    chk("async_rst_d", int'(fifo_d), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    bus_read(1'b1, d);
    chk("post_rst_status", int'(d), 8'h00);
    cyc(4);

    // Random: write-heavy, then read-heavy.
    for (int i = 0; i < 1500; i++) begin
      rx_stb  = ($urandom_range(0, 1) == 0);
      rx_data = 8'($urandom);
      bus_rd  = ($urandom_range(0, 5) == 0);
      bus_adr = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    for (int i = 0; i < 1000; i++) begin
      rx_stb  = ($urandom_range(0, 7) == 0);
      rx_data = 8'($urandom);
      bus_rd  = ($urandom_range(0, 1) == 0);
      bus_adr = 1'($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    rx_stb = 1'b0;
    bus_rd = 1'b0;
    cyc(6);
    for (int i = 0; i < 20; i++) bus_read(1'b0, d);
    bus_read(1'b1, d);
    bus_read(1'b1, d);
    chk("final_status", int'(d), 8'h00);
    cyc(2);
    chk("wr_queue_empty", wr_exp.size(), 0);
    chk("rd_queue_empty", rd_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
